package_monitor: RTL
====================

Name: package_monitor

Overview:
- Downstream consumer of the header decoder's per-package pulse and decoded header fields (timestamp, spill, slot, crate, event number).
- Checks package-stream integrity: event-number continuity within a spill, spill-number increment, strict timestamp monotonicity, and slot/crate identity.
- Produces one-cycle result strobes, sticky error flags and saturating counters for the SFP test readout.

Parameters:
- TOT_W, 32, width of total package counter
- ERR_W, 16, width of error counter and per-spill package counters

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- get_package  in  1  package-found strobe; fields valid in the same cycle
- r_timestamp  in  29  decoded timestamp
- r_spillno  in  10  decoded spill number
- r_slotno  in  5  decoded slot number
- r_crateno  in  5  decoded crate number
- r_evtno  in  16  decoded event number
- exp_slot  in  5  expected slot number (static config)
- exp_crate  in  5  expected crate number (static config)
- clr  in  1  clear counters, sticky flags and tracking state
- pkg_valid  out  1  one-cycle strobe: package processed
- evt_err  out  1  event-number discontinuity (qualified by pkg_valid)
- spill_err  out  1  spill-number not previous+1 (qualified by pkg_valid)
- ts_err  out  1  timestamp not strictly increasing (qualified by pkg_valid)
- id_err  out  1  slot/crate mismatch (qualified by pkg_valid)
- spill_change  out  1  first package of a new spill (qualified by pkg_valid)
- err_sticky  out  4  {id, ts, spill, evt} sticky flags
- tot_count  out  TOT_W  packages accepted, saturating
- err_count  out  ERR_W  packages with at least one error, saturating
- spill_count  out  ERR_W  packages in current spill, saturating
- last_spill_count  out  ERR_W  spill_count of previous spill, latched at spill change

Behaviour:
- Reset (rst=1 at a clk edge):
  - all outputs 0; state IDLE; internal last_evtno/last_spill/last_ts 0.
  - rst overrides clr and get_package.
- Accept: a package is accepted only on the rising edge of get_package (get_package=1 and previous-cycle get_package=0). Fields are sampled in that cycle. A multi-cycle high counts once.
- Latency: pkg_valid and all per-package flags assert exactly 1 cycle after the accepting cycle, for 1 cycle. Counters and sticky flags update in that same cycle.
- States:
  - IDLE: no reference held. On accept: load last_*; spill_count=1; tot_count+1; only id check applied; spill_change=0; go to TRACK.
  - TRACK, accept with r_spillno == last_spill:
    - evt_err if r_evtno != last_evtno+1 (mod 2^16; 0xFFFF->0x0000 is legal).
    - ts_err if r_timestamp <= last_ts (unsigned 29-bit; no wrap allowance).
    - spill_count+1.
  - TRACK, accept with r_spillno != last_spill:
    - spill_change=1.
    - spill_err if r_spillno != last_spill+1 (mod 1024; 1023->0 is legal).
    - evt_err if r_evtno != 0.
    - No timestamp check.
    - last_spill_count <= spill_count; spill_count <= 1.
- id_err: in any state, if r_slotno != exp_slot or r_crateno != exp_crate.
- Every accept:
  - last_* <= sampled fields, including after an error; tracking resynchronises to the received values.
  - tot_count+1.
  - err_count+1 if any error flag is set.
  - err_sticky |= flags.
- Saturation: counters hold at all-ones; they never wrap.
- clr=1: counters, last_spill_count and err_sticky set to 0; state to IDLE.
  - If clr and an accept occur in the same cycle, the clear applies first and the package is processed as the IDLE first package: tot_count=1, spill_count=1, only id check.
  - clr does not mask a pkg_valid already due from the previous cycle's accept.
- No back-pressure; a new accept is possible every second cycle (edge rule), and every accept is processed.

Test Plan:
- Reset, then accept spill=5, evt=0,1,2, ts=100,200,300, slot/crate match -> 3 pkg_valid pulses 1 cycle after each accept, no errors, tot_count=3, spill_count=3.
- Same spill, evt 2 followed by evt 4, ts increasing -> evt_err=1, err_sticky=4'b0001, err_count=1; next evt 5 -> no error (resync).
- Spill 5 with 3 packages, then spill 6 evt 0 -> spill_change=1, last_spill_count=3, spill_count=1; then spill 8 evt 1 -> spill_err=1 and evt_err=1, err_count+1.
- ts 300 followed by ts 300 in same spill -> ts_err=1; evt 0xFFFF followed by 0x0000 -> no evt_err; spill 1023 followed by 0 -> no spill_err.
- exp_slot=3, package with slot 4 -> id_err=1 on the first package from IDLE; get_package held high 4 cycles -> exactly one pkg_valid.
- clr asserted together with an accept while in TRACK -> tot_count=1, err_sticky=0, no evt/ts/spill check on that package; rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/package_monitor.sv
// Package-stream integrity monitor: checks event/spill continuity, timestamp order and
// slot/crate identity on each accepted package header, with sticky flags and counters.
module package_monitor #(
    parameter int unsigned TOT_W = 32,
    parameter int unsigned ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             get_package,
    input  logic [28:0]      r_timestamp,
    input  logic [9:0]       r_spillno,
    input  logic [4:0]       r_slotno,
    input  logic [4:0]       r_crateno,
    input  logic [15:0]      r_evtno,
    input  logic [4:0]       exp_slot,
    input  logic [4:0]       exp_crate,
    input  logic             clr,
    output logic             pkg_valid,
    output logic             evt_err,
    output logic             spill_err,
    output logic             ts_err,
    output logic             id_err,
    output logic             spill_change,
    output logic [3:0]       err_sticky,
    output logic [TOT_W-1:0] tot_count,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] spill_count,
    output logic [ERR_W-1:0] last_spill_count
);

    typedef enum logic [0:0] {StIdle, StTrack} state_e;

    localparam logic [TOT_W-1:0] TotOne = TOT_W'(1);
    localparam logic [ERR_W-1:0] ErrOne = ERR_W'(1);

    state_e            state_q, state_d;
    logic              get_q;
    logic              accept;
    logic [15:0]       last_evt_q, last_evt_d;
    logic [9:0]        last_spill_q, last_spill_d;
    logic [28:0]       last_ts_q, last_ts_d;
    logic              valid_q, valid_d;
    logic              evt_q, evt_d, spill_q, spill_d, ts_q, ts_d, id_q, id_d, chg_q, chg_d;
    logic [3:0]        sticky_q, sticky_d, sticky_base;
    logic [TOT_W-1:0]  tot_q, tot_d, tot_base;
    logic [ERR_W-1:0]  err_q, err_d, err_base;
    logic [ERR_W-1:0]  scnt_q, scnt_d, scnt_base;
    logic [ERR_W-1:0]  lscnt_q, lscnt_d;
    logic              from_idle;

    assign accept = get_package & ~get_q;

    always_comb begin
        state_d      = state_q;
        last_evt_d   = last_evt_q;
        last_spill_d = last_spill_q;
        last_ts_d    = last_ts_q;
        valid_d      = accept;
        evt_d        = 1'b0;
        spill_d      = 1'b0;
        ts_d         = 1'b0;
        id_d         = 1'b0;
        chg_d        = 1'b0;
        // A clear in the accepting cycle takes effect before the package is processed.
        tot_base     = clr ? '0 : tot_q;
        err_base     = clr ? '0 : err_q;
        scnt_base    = clr ? '0 : scnt_q;
        sticky_base  = clr ? 4'b0 : sticky_q;
        from_idle    = clr || (state_q == StIdle);
        tot_d        = tot_base;
        err_d        = err_base;
        scnt_d       = scnt_base;
        lscnt_d      = clr ? '0 : lscnt_q;
        sticky_d     = sticky_base;
        if (clr) begin
            state_d      = StIdle;
            last_evt_d   = '0;
            last_spill_d = '0;
            last_ts_d    = '0;
        end
        if (accept) begin
            id_d = (r_slotno != exp_slot) || (r_crateno != exp_crate);
            if (from_idle) begin
                scnt_d  = ErrOne;
                state_d = StTrack;
            end else if (r_spillno == last_spill_q) begin
                evt_d  = r_evtno != last_evt_q + 16'd1;
                ts_d   = r_timestamp <= last_ts_q;
                scnt_d = (scnt_base == '1) ? scnt_base : scnt_base + ErrOne;
            end else begin
                chg_d   = 1'b1;
                spill_d = r_spillno != last_spill_q + 10'd1;
                evt_d   = r_evtno != 16'd0;
                lscnt_d = scnt_base;
                scnt_d  = ErrOne;
            end
            last_evt_d   = r_evtno;
            last_spill_d = r_spillno;
            last_ts_d    = r_timestamp;
            tot_d        = (tot_base == '1) ? tot_base : tot_base + TotOne;
            if (evt_d || spill_d || ts_d || id_d) begin
                err_d = (err_base == '1) ? err_base : err_base + ErrOne;
            end
            sticky_d = sticky_base | {id_d, ts_d, spill_d, evt_d};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            get_q        <= 1'b0;
            last_evt_q   <= '0;
            last_spill_q <= '0;
            last_ts_q    <= '0;
            valid_q      <= 1'b0;
            evt_q        <= 1'b0;
            spill_q      <= 1'b0;
            ts_q         <= 1'b0;
            id_q         <= 1'b0;
            chg_q        <= 1'b0;
            sticky_q     <= '0;
            tot_q        <= '0;
            err_q        <= '0;
            scnt_q       <= '0;
            lscnt_q      <= '0;
        end else begin
            state_q      <= state_d;
            get_q        <= get_package;
            last_evt_q   <= last_evt_d;
            last_spill_q <= last_spill_d;
            last_ts_q    <= last_ts_d;
            valid_q      <= valid_d;
            evt_q        <= evt_d;
            spill_q      <= spill_d;
            ts_q         <= ts_d;
            id_q         <= id_d;
            chg_q        <= chg_d;
            sticky_q     <= sticky_d;
            tot_q        <= tot_d;
            err_q        <= err_d;
            scnt_q       <= scnt_d;
            lscnt_q      <= lscnt_d;
        end
    end

    assign pkg_valid        = valid_q;
    assign evt_err          = evt_q;
    assign spill_err        = spill_q;
    assign ts_err           = ts_q;
    assign id_err           = id_q;
    assign spill_change     = chg_q;
    assign err_sticky       = sticky_q;
    assign tot_count        = tot_q;
    assign err_count        = err_q;
    assign spill_count      = scnt_q;
    assign last_spill_count = lscnt_q;

endmodule
